selfcal_rx: RTL and testbench
=============================

SELFCAL_RX -- requirements
Module: selfcal_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4096, cycles spent in WAIT_REQ before timeout; legal range 2..65535.
REQ-002 Port: clk  input  1  single clock, all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_en  input  1  enables the self-cal responder; low means abort or exit.
REQ-005 Port: i_sideband_valid  input  1  i_decoded_sideband_message is valid this cycle.
REQ-006 Port: i_decoded_sideband_message  input  4  decoded partner message; 4'b0001 is END_REQ.
REQ-007 Port: i_busy_negedge_detected  input  1  sideband transmit-busy falling edge, meaning the current message has been sent.
REQ-008 Port: i_valid_tx  input  1  the sibling initiator holds the sideband mux.
REQ-009 Port: o_sideband_message  output  4  message to send; 4'b0010 is END_RESP, 4'b0000 is none.
REQ-010 Port: o_valid_rx  output  1  o_sideband_message is pending transmission.
REQ-011 Port: o_test_ack  output  1  the responder handshake is complete.
REQ-012 Port: o_timeout  output  1  no END_REQ arrived within TIMEOUT_CYCLES.

Function
REQ-013 FSM states SHALL be IDLE, CAL_ALGO, WAIT_REQ, SEND_RESP, TEST_FINISHED and TIMEOUT, with the state held in a register.
REQ-014 IDLE SHALL move to CAL_ALGO on the first cycle i_en=1; otherwise it SHALL stay in IDLE.
REQ-015 CAL_ALGO SHALL last exactly one cycle and then move to WAIT_REQ.
REQ-016 A sticky req_seen flag SHALL set when i_sideband_valid=1 and message=4'b0001 in CAL_ALGO or WAIT_REQ, so an early END_REQ is not lost.
REQ-017 WAIT_REQ SHALL move to SEND_RESP when req_seen=1 or when a valid END_REQ arrives this cycle.
REQ-018 On the clock edge that enters SEND_RESP, o_sideband_message SHALL become 4'b0010 and o_valid_rx SHALL become 1, giving one cycle of latency from END_REQ accept.
REQ-019 In SEND_RESP, o_valid_rx SHALL clear on the edge after a cycle with i_busy_negedge_detected=1 and i_valid_tx=0.
- On that same edge: o_sideband_message becomes 4'b0000, o_test_ack becomes 1, and the state moves to TEST_FINISHED.
REQ-020 In SEND_RESP, if i_busy_negedge_detected=1 while i_valid_tx=1, o_valid_rx SHALL stay 1 and the state SHALL not change.
REQ-021 In TEST_FINISHED, o_test_ack SHALL stay 1 until i_en=0, then the state SHALL return to IDLE.
REQ-022 Messages other than END_REQ, and any message outside CAL_ALGO/WAIT_REQ, SHALL be ignored; a duplicate END_REQ in SEND_RESP SHALL have no effect.
REQ-023 i_en=0 in any state SHALL cause the following on the next edge:
- state returns to IDLE;
- o_sideband_message, o_valid_rx and o_test_ack clear;
- req_seen and the timeout counter clear.
REQ-024 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, count only in WAIT_REQ, saturate, and clear on leaving WAIT_REQ.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 with no END_REQ, the FSM SHALL enter TIMEOUT with o_timeout=1 on that edge; it SHALL leave only via i_en=0.
REQ-026 If END_REQ arrives in the same cycle the counter hits its limit, SEND_RESP SHALL win.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the following until rst_n=1:
- state to IDLE;
- o_sideband_message=4'b0000, o_valid_rx=0, o_test_ack=0, o_timeout=0;
- req_seen=0 and counter=0.
REQ-028 Reset asserted mid-handshake SHALL abandon the handshake; after reset release, a fresh i_en rise is required.

Configuration
REQ-029 The macro SELFCAL_RX_TIMEOUT_EN SHALL control the timeout feature.
- Defined: the counter, the TIMEOUT state and o_timeout are implemented as in REQ-024..026.
- Undefined: there is no counter, WAIT_REQ waits indefinitely, and o_timeout is tied to 0 (the port is still present).

Structure
REQ-030 A shared package SHALL hold the sideband encodings SB_NONE=4'b0000, SB_END_REQ=4'b0001 and SB_END_RESP=4'b0010, plus the selfcal FSM state typedef.
- The initiator block shall use the same package.
REQ-031 The timeout counter SHALL be the sub-module selfcal_rx_timer, instantiated only under SELFCAL_RX_TIMEOUT_EN; all other logic stays in one module.

Verification
REQ-032 i_en rises at t0 and END_REQ (valid) arrives at t0+3 -> o_valid_rx=1 and message=4'b0010 at t0+4; busy negedge with i_valid_tx=0 at t0+6 -> o_test_ack=1, message=4'b0000, o_valid_rx=0 at t0+7.
REQ-033 END_REQ arrives during CAL_ALGO -> req_seen set; SEND_RESP is entered on the edge after WAIT_REQ is entered.
REQ-034 Busy negedge with i_valid_tx=1 -> o_valid_rx stays 1; a later negedge with i_valid_tx=0 completes the handshake.
REQ-035 i_en drops during SEND_RESP -> all outputs 0 and state IDLE on the next edge; a later i_en rise and END_REQ complete normally.
REQ-036 With SELFCAL_RX_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, no END_REQ -> o_timeout=1 after 8 WAIT_REQ cycles; END_REQ in the limit cycle -> SEND_RESP and o_timeout=0.
REQ-037 rst_n asserted asynchronously mid-SEND_RESP -> outputs clear immediately, before the next clock edge.

Source files
------------

// File: rtl/selfcal_rx_pkg.sv
// Shared encodings and FSM state type for the self-calibration sideband
// handshake. Used by the responder (selfcal_rx) and the sibling initiator.
package selfcal_rx_pkg;

  // Decoded sideband message encodings
  localparam logic [3:0] SB_NONE     = 4'b0000;
  localparam logic [3:0] SB_END_REQ  = 4'b0001;
  localparam logic [3:0] SB_END_RESP = 4'b0010;

  // Self-cal FSM states
  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_CAL_ALGO      = 3'd1,
    S_WAIT_REQ      = 3'd2,
    S_SEND_RESP     = 3'd3,
    S_TEST_FINISHED = 3'd4,
    S_TIMEOUT       = 3'd5
  } selfcal_state_e;

  // True when the partner delivers a valid END_REQ this cycle
  function automatic logic is_end_req(input logic valid, input logic [3:0] msg);
    return valid && (msg == SB_END_REQ);
  endfunction

endpackage

// File: rtl/selfcal_rx_timer.sv
// Saturating WAIT_REQ timeout counter for selfcal_rx. hit_o flags the last
// permitted waiting cycle (count == LIMIT-1) while counting is enabled.
module selfcal_rx_timer #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear has priority, otherwise count up until saturated
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_W'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign hit_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/selfcal_rx.sv
// Self-calibration sideband responder: waits for END_REQ from the partner,
// answers with END_RESP once the sideband mux is free, then reports
// o_test_ack until i_en drops.
// Build option: define SELFCAL_RX_TIMEOUT_EN to add the WAIT_REQ timeout
// (counter, TIMEOUT state, o_timeout); without it WAIT_REQ waits forever.
module selfcal_rx
  import selfcal_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_sideband_valid,
  input  logic [3:0] i_decoded_sideband_message,
  input  logic       i_busy_negedge_detected,
  input  logic       i_valid_tx,
  output logic [3:0] o_sideband_message,
  output logic       o_valid_rx,
  output logic       o_test_ack,
  output logic       o_timeout
);

  selfcal_state_e state_q, state_d;
  logic [3:0]     msg_q, msg_d;
  logic           valid_q, valid_d;
  logic           ack_q, ack_d;
  logic           req_seen_q, req_seen_d;
  logic           end_req;
  logic           timer_hit;

  assign end_req = is_end_req(i_sideband_valid, i_decoded_sideband_message);

  // Next-state and registered-output logic
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    msg_d      = msg_q;
    valid_d    = valid_q;
    ack_d      = ack_q;
    req_seen_d = req_seen_q;

    if (!i_en) begin
      state_d    = S_IDLE;
      msg_d      = SB_NONE;
      valid_d    = 1'b0;
      ack_d      = 1'b0;
      req_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_CAL_ALGO;
        S_CAL_ALGO: begin
          // Remember an END_REQ that arrives before we start listening
          if (end_req) req_seen_d = 1'b1;
          state_d = S_WAIT_REQ;
        end
        S_WAIT_REQ: begin
          // A request in the limit cycle beats the timeout
          if (req_seen_q || end_req) begin
            req_seen_d = 1'b1;
            state_d    = S_SEND_RESP;
            msg_d      = SB_END_RESP;
            valid_d    = 1'b1;
          end else if (timer_hit) begin
            state_d = S_TIMEOUT;
          end
        end
        S_SEND_RESP: begin
          // Only a completed send on our own mux slot finishes the handshake
          if (i_busy_negedge_detected && !i_valid_tx) begin
            state_d = S_TEST_FINISHED;
            msg_d   = SB_NONE;
            valid_d = 1'b0;
            ack_d   = 1'b1;
          end
        end
        S_TEST_FINISHED: state_d = S_TEST_FINISHED;
        S_TIMEOUT:       state_d = S_TIMEOUT;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      msg_q      <= SB_NONE;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      req_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      req_seen_q <= req_seen_d;
    end
  end

`ifdef SELFCAL_RX_TIMEOUT_EN
  // Counts WAIT_REQ cycles; cleared whenever the FSM is not staying in WAIT_REQ
  selfcal_rx_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_d != S_WAIT_REQ),
    .en_i  (state_q == S_WAIT_REQ),
    .hit_o (timer_hit)
  );

  assign o_timeout = (state_q == S_TIMEOUT);
`else
  // No timer: WAIT_REQ waits indefinitely. The comparison folds to 0 for
  // every legal TIMEOUT_CYCLES.
  assign timer_hit = (TIMEOUT_CYCLES == 0);
  assign o_timeout = 1'b0;
`endif

  assign o_sideband_message = msg_q;
  assign o_valid_rx         = valid_q;
  assign o_test_ack         = ack_q;

endmodule

// File: tb/tb_selfcal_rx.sv
// Self-checking bench for selfcal_rx: a table of single-cycle vectors plus
// hand-written sequences for async reset, waiting and (when built with
// SELFCAL_RX_TIMEOUT_EN) the timeout limit.
module tb_selfcal_rx;

  localparam int unsigned TO_CYCLES = 8;

  logic       clk;
  logic       rst_n;
  logic       i_en;
  logic       i_sideband_valid;
  logic [3:0] i_decoded_sideband_message;
  logic       i_busy_negedge_detected;
  logic       i_valid_tx;
  logic [3:0] o_sideband_message;
  logic       o_valid_rx;
  logic       o_test_ack;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;

  selfcal_rx #(
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i_en                       (i_en),
    .i_sideband_valid           (i_sideband_valid),
    .i_decoded_sideband_message (i_decoded_sideband_message),
    .i_busy_negedge_detected    (i_busy_negedge_detected),
    .i_valid_tx                 (i_valid_tx),
    .o_sideband_message         (o_sideband_message),
    .o_valid_rx                 (o_valid_rx),
    .o_test_ack                 (o_test_ack),
    .o_timeout                  (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sbv;
    logic [3:0] msg;
    logic       busy;
    logic       vtx;
    logic [3:0] exp_msg;
    logic       exp_valid;
    logic       exp_ack;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Observed outputs packed as {message, valid_rx, test_ack, timeout}
  function automatic logic [6:0] obs();
    return {o_sideband_message, o_valid_rx, o_test_ack, o_timeout};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got msg=%b valid=%b ack=%b timeout=%b, expected msg=%b valid=%b ack=%b timeout=%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic en, input logic sbv, input logic [3:0] msg,
                       input logic busy, input logic vtx);
    i_en                       = en;
    i_sideband_valid           = sbv;
    i_decoded_sideband_message = msg;
    i_busy_negedge_detected    = busy;
    i_valid_tx                 = vtx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic sbv, input logic [3:0] msg,
                     input logic busy, input logic vtx, input logic [3:0] exp_msg,
                     input logic exp_valid, input logic exp_ack, input string name);
    vec_t v;
    v.en = en; v.sbv = sbv; v.msg = msg; v.busy = busy; v.vtx = vtx;
    v.exp_msg = exp_msg; v.exp_valid = exp_valid; v.exp_ack = exp_ack; v.name = name;
    vecs.push_back(v);
  endtask

  // From IDLE: i_en high for two edges lands in WAIT_REQ with the count at 0
  task automatic run_to_wait();
    drive(1, 0, 4'b0000, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    drive(0, 0, 4'b0000, 0, 0);
    rst_n = 1'b0;

    // Flow A: normal handshake, ignored traffic, busy while mux taken
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "a_idle");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "a_en_rise");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "a_cal_algo");
    add(1, 1, 4'b0011, 0, 0, 4'b0000, 0, 0, "a_other_msg");
    add(1, 1, 4'b0001, 0, 0, 4'b0010, 1, 0, "a_end_req");
    add(1, 1, 4'b0001, 0, 0, 4'b0010, 1, 0, "a_dup_req");
    add(1, 0, 4'b0000, 1, 1, 4'b0010, 1, 0, "a_busy_mux_taken");
    add(1, 0, 4'b0000, 1, 0, 4'b0000, 0, 1, "a_busy_done");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 1, "a_ack_hold");
    add(1, 1, 4'b0001, 1, 0, 4'b0000, 0, 1, "a_finished_ignores");
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "a_exit");
    // Flow B: END_REQ in IDLE or without valid ignored; early END_REQ kept
    add(1, 1, 4'b0001, 0, 0, 4'b0000, 0, 0, "b_idle_req_ignored");
    add(1, 0, 4'b0001, 0, 0, 4'b0000, 0, 0, "b_invalid_req_ignored");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "b_still_waiting");
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "b_exit");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "b_en_rise");
    add(1, 1, 4'b0001, 0, 0, 4'b0000, 0, 0, "b_early_req");
    add(1, 0, 4'b0000, 0, 0, 4'b0010, 1, 0, "b_early_req_resp");
    add(1, 0, 4'b0000, 0, 1, 4'b0010, 1, 0, "b_vtx_no_busy");
    // Flow C: i_en drop in SEND_RESP, then a fresh handshake
    add(0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0, "c_drop_en");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "c_en_rise");
    add(1, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "c_cal_algo");
    add(1, 1, 4'b0001, 0, 0, 4'b0010, 1, 0, "c_resp_again");
    add(1, 0, 4'b0000, 1, 0, 4'b0000, 0, 1, "c_done_again");
    add(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, "c_exit");

    // Reset state
    tick();
    tick();
    check("reset_state", obs(), 7'b0000_0_0_0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].sbv, vecs[i].msg, vecs[i].busy, vecs[i].vtx);
      tick();
      check(vecs[i].name, obs(), {vecs[i].exp_msg, vecs[i].exp_valid, vecs[i].exp_ack, 1'b0});
    end

    // Asynchronous reset in SEND_RESP clears outputs before the next edge
    run_to_wait();
    drive(1, 1, 4'b0001, 0, 0);
    tick();
    check("pre_reset_send_resp", obs(), 7'b0010_1_0_0);
    drive(1, 0, 4'b0000, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", obs(), 7'b0000_0_0_0);
    drive(0, 0, 4'b0000, 1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", obs(), 7'b0000_0_0_0);
    run_to_wait();
    drive(1, 1, 4'b0001, 0, 0);
    tick();
    check("post_reset_resp", obs(), 7'b0010_1_0_0);
    drive(1, 0, 4'b0000, 1, 0);
    tick();
    check("post_reset_ack", obs(), 7'b0000_0_1_0);
    drive(0, 0, 4'b0000, 0, 0);
    tick();

`ifdef SELFCAL_RX_TIMEOUT_EN
    // Eight WAIT_REQ cycles without END_REQ raise o_timeout
    run_to_wait();
    for (int i = 0; i < TO_CYCLES - 1; i++) tick();
    check("timeout_not_yet", obs(), 7'b0000_0_0_0);
    tick();
    check("timeout_fire", obs(), 7'b0000_0_0_1);
    drive(1, 1, 4'b0001, 0, 0);
    tick();
    check("timeout_ignores_req", obs(), 7'b0000_0_0_1);
    drive(0, 0, 4'b0000, 0, 0);
    tick();
    check("timeout_exit", obs(), 7'b0000_0_0_0);

    // END_REQ in the limit cycle wins over the timeout
    run_to_wait();
    for (int i = 0; i < TO_CYCLES - 1; i++) tick();
    drive(1, 1, 4'b0001, 0, 0);
    tick();
    check("req_at_limit", obs(), 7'b0010_1_0_0);
    drive(1, 0, 4'b0000, 1, 0);
    tick();
    check("req_at_limit_ack", obs(), 7'b0000_0_1_0);
    drive(0, 0, 4'b0000, 0, 0);
    tick();
`else
    // Without the timer, WAIT_REQ waits well past TIMEOUT_CYCLES
    run_to_wait();
    for (int i = 0; i < 3 * TO_CYCLES; i++) tick();
    check("wait_indefinite", obs(), 7'b0000_0_0_0);
    drive(1, 1, 4'b0001, 0, 0);
    tick();
    check("late_req_resp", obs(), 7'b0010_1_0_0);
    drive(0, 0, 4'b0000, 0, 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
